// File: rtl/timer_irq_ctrl.sv
// Timer0 interrupt controller.
// Watches the TIFR/TIMSK images and the global interrupt enable, arbitrates
// the three Timer0 sources with a fixed priority, and presents one vector to
// the CPU. When the CPU takes the vector, the controller emits a one-cycle
// hardware-clear strobe for the flag. It then idles one cycle so the TIFR
// write-back lands before the controller re-arbitrates.
module timer_irq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_COMPA  = 9,
  parameter int VEC_COMPB  = 10,
  parameter int VEC_OVF    = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_tifr,
  input  logic [DATA_WIDTH-1:0] mem_timsk,
  input  logic                  sreg_i,
  input  logic                  irq_ack,
  output logic                  irq_req,
  output logic [3:0]            irq_vector,
  output logic                  tifr_clr,
  output logic [DATA_WIDTH-1:0] tifr_clr_mask
);

  // Flag bit positions inside TIFR/TIMSK.
  localparam logic [1:0] BIT_TOV0  = 2'd0;
  localparam logic [1:0] BIT_OCF0A = 2'd1;
  localparam logic [1:0] BIT_OCF0B = 2'd2;

  localparam logic [3:0] VEC_A = 4'(VEC_COMPA);
  localparam logic [3:0] VEC_B = 4'(VEC_COMPB);
  localparam logic [3:0] VEC_O = 4'(VEC_OVF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    CLR   = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] src_reg, src_next;   // latched TIFR bit index of the winner
  logic [3:0] vec_reg, vec_next;   // latched vector of the winner

  logic [2:0] pend;
  logic       any_pend;
  logic [1:0] win_bit;
  logic [3:0] win_vec;
  logic       src_pending;

  // Only bits 2:0 are Timer0 sources; the rest of the bus is not used here.
  generate
    if (DATA_WIDTH > 3) begin : g_unused
      logic unused_upper;
      assign unused_upper = ^{mem_tifr[DATA_WIDTH-1:3], mem_timsk[DATA_WIDTH-1:3]};
    end
  endgenerate

  // Per-source pending: flag AND enable AND global interrupt enable.
  assign pend     = mem_tifr[2:0] & mem_timsk[2:0] & {3{sreg_i}};
  assign any_pend = |pend;

  // Fixed priority arbitration: compare-A, then compare-B, then overflow.
  always_comb begin
    win_bit = BIT_TOV0;
    win_vec = VEC_O;
    if (pend[BIT_OCF0A]) begin
      win_bit = BIT_OCF0A;
      win_vec = VEC_A;
    end else if (pend[BIT_OCF0B]) begin
      win_bit = BIT_OCF0B;
      win_vec = VEC_B;
    end
  end

  // Is the source latched at request time still pending now?
  always_comb begin
    src_pending = 1'b0;
    case (src_reg)
      BIT_TOV0:  src_pending = pend[0];
      BIT_OCF0A: src_pending = pend[1];
      BIT_OCF0B: src_pending = pend[2];
      default:   src_pending = 1'b0;
    endcase
  end

  // State and latched-source registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      src_reg   <= 2'd0;
      vec_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      vec_reg   <= vec_next;
    end
  end

  // Next-state logic. The latch only loads in IDLE, so a higher-priority
  // source appearing during PEND cannot displace the presented vector.
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    vec_next   = vec_reg;
    case (state_reg)
      IDLE: begin
        if (any_pend) begin
          state_next = PEND;
          src_next   = win_bit;
          vec_next   = win_vec;
        end
      end
      PEND: begin
        // Acknowledge takes precedence over a simultaneous withdraw.
        if (irq_ack) begin
          state_next = CLR;
        end else if (!src_pending) begin
          state_next = IDLE;
        end
      end
      CLR: begin
        state_next = GUARD;
      end
      GUARD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded purely from registers, so they are glitch-free and
  // drop to zero as soon as reset forces the state register to IDLE.
  always_comb begin
    irq_req       = (state_reg == PEND);
    irq_vector    = (state_reg == PEND) ? vec_reg : 4'd0;
    tifr_clr      = (state_reg == CLR);
    tifr_clr_mask = '0;
    if (state_reg == CLR) begin
      tifr_clr_mask[src_reg] = 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed self-checking bench for timer_irq_ctrl.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_timer_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] mem_tifr = 8'h00;
  logic [7:0] mem_timsk = 8'h00;
  logic       sreg_i = 1'b0;
  logic       irq_ack = 1'b0;
  logic       irq_req;
  logic [3:0] irq_vector;
  logic       tifr_clr;
  logic [7:0] tifr_clr_mask;

  int n_checks = 0;
  int n_fail   = 0;

  timer_irq_ctrl #(
    .DATA_WIDTH(8),
    .VEC_COMPA (9),
    .VEC_COMPB (10),
    .VEC_OVF   (11)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_tifr     (mem_tifr),
    .mem_timsk    (mem_timsk),
    .sreg_i       (sreg_i),
    .irq_ack      (irq_ack),
    .irq_req      (irq_req),
    .irq_vector   (irq_vector),
    .tifr_clr     (tifr_clr),
    .tifr_clr_mask(tifr_clr_mask)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Checks all four outputs against expected values.
  task automatic expect_out(input string tag, input logic req, input logic [3:0] vec,
                            input logic clr, input logic [7:0] mask);
    check({tag, ".req"},  {31'd0, irq_req}, {31'd0, req});
    check({tag, ".vec"},  {28'd0, irq_vector}, {28'd0, vec});
    check({tag, ".clr"},  {31'd0, tifr_clr}, {31'd0, clr});
    check({tag, ".mask"}, {24'd0, tifr_clr_mask}, {24'd0, mask});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, before any clock edge.
    #2;
    expect_out("reset_hold", 1'b0, 4'd0, 1'b0, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    expect_out("after_release", 1'b0, 4'd0, 1'b0, 8'h00);

    // Single overflow source: request, ack, clear strobe, guard.
    mem_tifr = 8'h01; mem_timsk = 8'h01; sreg_i = 1'b1;
    tick();
    expect_out("ovf_pend", 1'b1, 4'd11, 1'b0, 8'h00);
    irq_ack = 1'b1;
    tick();
    expect_out("ovf_clr", 1'b0, 4'd0, 1'b1, 8'h01);
    irq_ack = 1'b0; mem_tifr = 8'h00;
    tick();
    expect_out("ovf_guard", 1'b0, 4'd0, 1'b0, 8'h00);
    tick();
    expect_out("ovf_idle", 1'b0, 4'd0, 1'b0, 8'h00);

    // All three pending: served in priority order 9, 10, 11.
    mem_tifr = 8'h07; mem_timsk = 8'h07;
    tick();
    expect_out("prio_a", 1'b1, 4'd9, 1'b0, 8'h00);
    irq_ack = 1'b1;
    tick();
    expect_out("prio_a_clr", 1'b0, 4'd0, 1'b1, 8'h02);
    irq_ack = 1'b0; mem_tifr = 8'h05;
    tick();
    expect_out("prio_a_guard", 1'b0, 4'd0, 1'b0, 8'h00);
    tick();
    expect_out("prio_a_idle", 1'b0, 4'd0, 1'b0, 8'h00);
    tick();
    expect_out("prio_b", 1'b1, 4'd10, 1'b0, 8'h00);
    irq_ack = 1'b1;
    tick();
    expect_out("prio_b_clr", 1'b0, 4'd0, 1'b1, 8'h04);
    irq_ack = 1'b0; mem_tifr = 8'h01;
    tick();
    tick();
    expect_out("prio_b_idle", 1'b0, 4'd0, 1'b0, 8'h00);
    tick();
    expect_out("prio_o", 1'b1, 4'd11, 1'b0, 8'h00);
    irq_ack = 1'b1;
    tick();
    expect_out("prio_o_clr", 1'b0, 4'd0, 1'b1, 8'h01);
    irq_ack = 1'b0; mem_tifr = 8'h00;
    tick();
    tick();

    // No re-arbitration while pending on vector 10.
    mem_tifr = 8'h04;
    tick();
    expect_out("hold_b", 1'b1, 4'd10, 1'b0, 8'h00);
    mem_tifr = 8'h06;
    tick();
    expect_out("hold_b_new_a", 1'b1, 4'd10, 1'b0, 8'h00);
    tick();
    expect_out("hold_b_still", 1'b1, 4'd10, 1'b0, 8'h00);
    irq_ack = 1'b1;
    tick();
    expect_out("hold_b_clr", 1'b0, 4'd0, 1'b1, 8'h04);
    irq_ack = 1'b0; mem_tifr = 8'h02;
    tick();
    tick();
    tick();
    expect_out("hold_then_a", 1'b1, 4'd9, 1'b0, 8'h00);
    irq_ack = 1'b1;
    tick();
    expect_out("hold_then_a_clr", 1'b0, 4'd0, 1'b1, 8'h02);
    irq_ack = 1'b0; mem_tifr = 8'h00;
    tick();
    tick();

    // Withdraw by dropping the global enable: no clear strobe.
    mem_tifr = 8'h01;
    tick();
    expect_out("wd_pend", 1'b1, 4'd11, 1'b0, 8'h00);
    sreg_i = 1'b0;
    tick();
    expect_out("wd_drop", 1'b0, 4'd0, 1'b0, 8'h00);
    tick();
    expect_out("wd_quiet", 1'b0, 4'd0, 1'b0, 8'h00);
    mem_tifr = 8'h00; sreg_i = 1'b1;
    tick();

    // Stray ack in IDLE is ignored.
    irq_ack = 1'b1;
    tick();
    expect_out("stray_ack", 1'b0, 4'd0, 1'b0, 8'h00);
    irq_ack = 1'b0;
    tick();
    expect_out("stray_ack_after", 1'b0, 4'd0, 1'b0, 8'h00);

    // Asynchronous reset during CLR aborts the strobe; request resumes after.
    mem_tifr = 8'h02; mem_timsk = 8'h02;
    tick();
    expect_out("rst_pend", 1'b1, 4'd9, 1'b0, 8'h00);
    irq_ack = 1'b1;
    tick();
    expect_out("rst_in_clr", 1'b0, 4'd0, 1'b1, 8'h02);
    irq_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    expect_out("rst_async", 1'b0, 4'd0, 1'b0, 8'h00);
    tick();
    expect_out("rst_held", 1'b0, 4'd0, 1'b0, 8'h00);
    reset = 1'b1;
    tick();
    expect_out("rst_rerequest", 1'b1, 4'd9, 1'b0, 8'h00);
    irq_ack = 1'b1;
    tick();
    expect_out("rst_rerequest_clr", 1'b0, 4'd0, 1'b1, 8'h02);
    irq_ack = 1'b0; mem_tifr = 8'h00;
    tick();
    tick();
    expect_out("final_idle", 1'b0, 4'd0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the TIFR/TIMSK/clear-mask buses.
REQ-002 Parameter VEC_COMPA, default 9, SHALL be the vector number for the Timer0 compare-A interrupt.
REQ-003 Parameter VEC_COMPB, default 10, SHALL be the vector number for the Timer0 compare-B interrupt.
REQ-004 Parameter VEC_OVF, default 11, SHALL be the vector number for the Timer0 overflow interrupt.
REQ-005 clk  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-006 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 mem_tifr  in  DATA_WIDTH  SHALL carry the current TIFR contents: bit0 TOV0, bit1 OCF0A, bit2 OCF0B.
REQ-008 mem_timsk  in  DATA_WIDTH  SHALL carry the current TIMSK contents: bit0 TOIE0, bit1 OCIE0A, bit2 OCIE0B.
REQ-009 sreg_i  in  1  SHALL be the global interrupt enable (SREG I bit).
REQ-010 irq_ack  in  1  SHALL be the one-cycle CPU acknowledge that the presented vector is taken.
REQ-011 irq_req  out  1  SHALL be the registered interrupt request to the CPU.
REQ-012 irq_vector  out  4  SHALL carry the latched vector number while irq_req is high.
REQ-013 tifr_clr  out  1  SHALL be a one-cycle strobe requesting hardware clear of a TIFR flag.
REQ-014 tifr_clr_mask  out  DATA_WIDTH  SHALL be one-hot, naming the flag to clear while tifr_clr is high; zero otherwise.

Function
REQ-015 A source SHALL be pending when its TIFR flag AND its TIMSK enable are 1 AND sreg_i is 1; bits 7:3 SHALL be ignored.
REQ-016 Priority SHALL be fixed: OCF0A > OCF0B > TOV0 (lowest vector wins).
REQ-017 The FSM SHALL have states IDLE, PEND, CLR, GUARD.
REQ-018 IDLE: on any pending source, go to PEND at the next edge and latch the winning source and its vector.
REQ-019 PEND: irq_req SHALL be 1 and irq_vector SHALL hold the latched vector, stable until leaving PEND.
REQ-020 PEND: if irq_ack is 1, go to CLR; the withdraw check SHALL be ignored in that cycle (ack wins).
REQ-021 PEND without ack: if the latched source is no longer pending (flag cleared, enable cleared, or sreg_i low), return to IDLE with no clear strobe.
REQ-022 PEND: a newly pending higher-priority source SHALL NOT re-arbitrate; the latched vector is held.
REQ-023 CLR: tifr_clr SHALL be 1 for exactly one cycle, with tifr_clr_mask = one-hot of the latched flag bit; then go to GUARD.
REQ-024 GUARD: one cycle with no request, covering the TIFR write-back; then go to IDLE.
REQ-025 Latency: a source pending at edge N SHALL give irq_req = 1 after edge N; ack sampled at edge M SHALL give irq_req = 0 and tifr_clr = 1 after edge M.
REQ-026 A source still pending after GUARD SHALL be re-requested no earlier than 3 cycles after the ack edge.
REQ-027 irq_ack outside PEND SHALL be ignored.
REQ-028 irq_vector SHALL be 0 outside PEND.

Reset
REQ-029 While reset = 0, the FSM SHALL be IDLE, irq_req = 0, irq_vector = 0, tifr_clr = 0, tifr_clr_mask = 0, and the latched source cleared, independent of clk.
REQ-030 Reset asserted mid-request (PEND or CLR) SHALL abort immediately with no clear strobe; after release, a still-pending source SHALL be requested normally.

Verification
REQ-031 TIFR = 0x01, TIMSK = 0x01, sreg_i = 1 -> irq_req = 1, irq_vector = 11 one cycle later; ack -> tifr_clr = 1, mask = 0x01 for one cycle.
REQ-032 TIFR = 0x07, TIMSK = 0x07 -> vector 9, mask 0x02; with TIFR then 0x05, vector 10; then vector 11, each after GUARD.
REQ-033 PEND on vector 10, then TIFR bit1 set -> irq_vector stays 10 until ack.
REQ-034 PEND on vector 11, then sreg_i = 0 with no ack -> irq_req = 0 next cycle, tifr_clr never pulses.
REQ-035 irq_ack pulsed in IDLE with TIFR = 0 -> no state change, all outputs 0.
REQ-036 reset = 0 asserted during CLR -> all outputs 0 asynchronously; release with TIFR = 0x02, TIMSK = 0x02 -> irq_req = 1, vector 9.
